// File: rtl/beta_pkg.sv
// Shared types for the decode-stage pipeline controller.
// PIPE_BYPASS_EN selects operand bypassing instead of full interlocks.
package beta_pkg;

  localparam logic [4:0] R31 = 5'd31;
  localparam logic [4:0] XP  = 5'd30;

  typedef enum logic [1:0] {
    BYP_RF  = 2'b00,
    BYP_EX  = 2'b01,
    BYP_MEM = 2'b10,
    BYP_WB  = 2'b11
  } bypass_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_TAKE,
    ST_MASK
  } irq_st_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rc;
    logic       load;
  } tag_t;

endpackage

// File: rtl/hazard_cmp.sv
// Per-operand hazard compare against the EX/MEM/WB destination tags.
// PIPE_BYPASS_EN: youngest-match bypass, else interlock on any match.
module hazard_cmp
  import beta_pkg::*;
(
  input  logic       uses_i,
  input  logic [4:0] src_i,
  input  tag_t       ex_i,
  input  tag_t       mem_i,
  input  tag_t       wb_i,
  output bypass_e    sel_o,
  output logic       stall_o
);

  logic live;
  logic m_ex;
  logic m_mem;
  logic m_wb;
  logic unused_load;

  assign live  = uses_i && (src_i != R31);
  assign m_ex  = live && ex_i.valid && (ex_i.rc == src_i);
  assign m_mem = live && mem_i.valid && (mem_i.rc == src_i);
  assign m_wb  = live && wb_i.valid && (wb_i.rc == src_i);
  assign unused_load = ^{ex_i.load, mem_i.load, wb_i.load};

`ifdef PIPE_BYPASS_EN
  always_comb begin
    sel_o = BYP_RF;
    if (m_ex)
      sel_o = BYP_EX;
    else if (m_mem)
      sel_o = BYP_MEM;
    else if (m_wb)
      sel_o = BYP_WB;
  end

  // load data only exists once the load reaches WB
  assign stall_o = (m_ex && ex_i.load) ||
                   (m_mem && mem_i.load);
`else
  assign sel_o   = BYP_RF;
  assign stall_o = m_ex || m_mem || m_wb;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage hazard, annul and interrupt-entry controller.
// PIPE_BYPASS_EN enables bypass selects; default build interlocks.
module pipe_ctrl
  import beta_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_ra,
  input  logic [4:0] id_rb,
  input  logic [4:0] id_rc,
  input  logic       id_uses_ra,
  input  logic       id_uses_rb,
  input  logic       id_writes_rc,
  input  logic       id_is_load,
  input  logic       id_branch_taken,
  input  logic       id_sup,
  input  logic       irq,
  output logic       stall,
  output logic       annul_if,
  output logic       bubble_ex,
  output logic [1:0] ra_sel,
  output logic [1:0] rb_sel,
  output logic       irq_take
);

  tag_t    ex_q;
  tag_t    ex_d;
  tag_t    mem_q;
  tag_t    wb_q;
  irq_st_e st_q;
  logic    rst_q;

  bypass_e sel_a;
  bypass_e sel_b;
  logic    haz_a;
  logic    haz_b;
  logic    quiet;
  logic    in_take;
  logic    stall_w;

  hazard_cmp u_ra (
    .uses_i  (id_uses_ra),
    .src_i   (id_ra),
    .ex_i    (ex_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (sel_a),
    .stall_o (haz_a)
  );

  hazard_cmp u_rb (
    .uses_i  (id_uses_rb),
    .src_i   (id_rb),
    .ex_i    (ex_q),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (sel_b),
    .stall_o (haz_b)
  );

  // outputs stay low in the reset cycle and the one after it
  assign quiet   = rst || rst_q;
  assign in_take = (st_q == ST_TAKE);

  assign stall_w = id_valid && (haz_a || haz_b) &&
                   !in_take && !quiet;

  assign stall     = stall_w;
  assign bubble_ex = stall_w;
  assign irq_take  = in_take && !quiet;
  assign annul_if  = (in_take && !quiet) ||
                     (id_branch_taken && id_valid &&
                      !stall_w && !quiet);
  assign ra_sel    = quiet ? BYP_RF : sel_a;
  assign rb_sel    = quiet ? BYP_RF : sel_b;

  always_comb begin
    ex_d = '0;
    if (in_take) begin
      ex_d = '{valid: 1'b1, rc: XP, load: 1'b0};
    end else if (!stall_w) begin
      ex_d.valid = id_valid && id_writes_rc &&
                   (id_rc != R31);
      ex_d.rc    = id_rc;
      ex_d.load  = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      st_q  <= ST_IDLE;
      rst_q <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      unique case (st_q)
        ST_IDLE:
          if (irq)
            st_q <= ST_PEND;
        ST_PEND:
          if (!irq)
            st_q <= ST_IDLE;
          else if (id_valid && !id_sup && !stall_w)
            st_q <= ST_TAKE;
        ST_TAKE:
          st_q <= ST_MASK;
        ST_MASK:
          if (!irq && !id_sup)
            st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with a behavioural reference model.
// Honours PIPE_BYPASS_EN the same way the design does.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic [4:0] id_rc;
  logic       id_uses_ra;
  logic       id_uses_rb;
  logic       id_writes_rc;
  logic       id_is_load;
  logic       id_branch_taken;
  logic       id_sup;
  logic       irq;
  logic       stall;
  logic       annul_if;
  logic       bubble_ex;
  logic [1:0] ra_sel;
  logic [1:0] rb_sel;
  logic       irq_take;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_ra           (id_ra),
    .id_rb           (id_rb),
    .id_rc           (id_rc),
    .id_uses_ra      (id_uses_ra),
    .id_uses_rb      (id_uses_rb),
    .id_writes_rc    (id_writes_rc),
    .id_is_load      (id_is_load),
    .id_branch_taken (id_branch_taken),
    .id_sup          (id_sup),
    .irq             (irq),
    .stall           (stall),
    .annul_if        (annul_if),
    .bubble_ex       (bubble_ex),
    .ra_sel          (ra_sel),
    .rb_sel          (rb_sel),
    .irq_take        (irq_take)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int ra;
    int rb;
    int rc;
    bit ua;
    bit ub;
    bit wr;
    bit ld;
    bit br;
    bit sup;
    bit irq;
    bit rst;
  } in_t;

  typedef struct {
    bit st;
    bit an;
    bit bu;
    bit tk;
    int ra;
    int rb;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // model: writers seen in the last three issue slots, age 0 = EX
  bit   w_v[3];
  int   w_rc[3];
  bit   w_ld[3];
  string irq_mode = "idle";
  bit   after_rst = 1'b0;

  task automatic chk(string nm, int act, int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", int'(stall), int'(e.st));
      chk("bubble_ex", int'(bubble_ex), int'(e.bu));
      chk("annul_if", int'(annul_if), int'(e.an));
      chk("irq_take", int'(irq_take), int'(e.tk));
      chk("ra_sel", int'(ra_sel), e.ra);
      chk("rb_sel", int'(rb_sel), e.rb);
    end
  end

  task automatic operand(input bit uses, input int src,
                         output bit haz, output int sel);
    bit found;
    haz   = 1'b0;
    sel   = 0;
    found = 1'b0;
    if (!uses || src == 31)
      return;
    for (int age = 0; age < 3; age++) begin
      if (w_v[age] && w_rc[age] == src) begin
`ifdef PIPE_BYPASS_EN
        if (!found)
          sel = age + 1;
        if (w_ld[age] && age < 2)
          haz = 1'b1;
`else
        haz = 1'b1;
`endif
        found = 1'b1;
      end
    end
  endtask

  task automatic drive(input in_t x);
    exp_t e;
    bit   ha, hb, stl, tk, q;
    int   sa, sb;
    @(posedge clk);
    #1;
    rst             = x.rst;
    id_valid        = x.v;
    id_ra           = 5'(x.ra);
    id_rb           = 5'(x.rb);
    id_rc           = 5'(x.rc);
    id_uses_ra      = x.ua;
    id_uses_rb      = x.ub;
    id_writes_rc    = x.wr;
    id_is_load      = x.ld;
    id_branch_taken = x.br;
    id_sup          = x.sup;
    irq             = x.irq;
    e = '{default: 0};
    if (x.rst) begin
      for (int i = 0; i < 3; i++)
        w_v[i] = 1'b0;
      irq_mode  = "idle";
      after_rst = 1'b1;
    end else begin
      q = after_rst;
      operand(x.ua, x.ra, ha, sa);
      operand(x.ub, x.rb, hb, sb);
      tk   = (irq_mode == "take");
      stl  = x.v && (ha || hb) && !tk && !q;
      e.st = stl;
      e.bu = stl;
      e.tk = tk && !q;
      e.an = e.tk || (x.br && x.v && !stl && !q);
      e.ra = q ? 0 : sa;
      e.rb = q ? 0 : sb;
      for (int i = 2; i > 0; i--) begin
        w_v[i]  = w_v[i-1];
        w_rc[i] = w_rc[i-1];
        w_ld[i] = w_ld[i-1];
      end
      if (tk) begin
        w_v[0] = 1'b1; w_rc[0] = 30; w_ld[0] = 1'b0;
      end else begin
        w_v[0]  = !stl && x.v && x.wr && x.rc != 31;
        w_rc[0] = x.rc;
        w_ld[0] = x.ld;
      end
      if (irq_mode == "idle") begin
        if (x.irq) irq_mode = "pend";
      end else if (irq_mode == "pend") begin
        if (!x.irq) irq_mode = "idle";
        else if (x.v && !x.sup && !stl) irq_mode = "take";
      end else if (irq_mode == "take") begin
        irq_mode = "mask";
      end else begin
        if (!x.irq && !x.sup) irq_mode = "idle";
      end
      after_rst = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  function automatic in_t nop();
    in_t x = '{default: 0};
    return x;
  endfunction

  function automatic in_t add(int rc, int ra, int rb);
    in_t x = '{default: 0};
    x.v = 1; x.wr = 1; x.ua = 1; x.ub = 1;
    x.rc = rc; x.ra = ra; x.rb = rb;
    return x;
  endfunction

  function automatic in_t ldi(int rc, int ra);
    in_t x = '{default: 0};
    x.v = 1; x.wr = 1; x.ua = 1; x.ld = 1;
    x.rc = rc; x.ra = ra;
    return x;
  endfunction

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 4) return 30;
    if (r == 5) return 31;
    return r;
  endfunction

  initial begin
    in_t x;
    int  wait_n;
    rst = 1'b1;
    id_valid = 0; id_ra = 0; id_rb = 0; id_rc = 0;
    id_uses_ra = 0; id_uses_rb = 0; id_writes_rc = 0;
    id_is_load = 0; id_branch_taken = 0; id_sup = 0;
    irq = 0;
    for (int i = 0; i < 3; i++) begin
      w_v[i] = 0; w_rc[i] = 0; w_ld[i] = 0;
    end

    x = nop(); x.rst = 1; drive(x);
    x = add(1, 1, 1); drive(x);
    drive(nop()); drive(nop()); drive(nop());

    drive(add(1, 5, 6)); drive(add(7, 1, 6));
    drive(add(1, 5, 6)); drive(nop()); drive(add(7, 1, 6));
    drive(add(1, 5, 6)); drive(nop()); drive(nop());
    drive(add(7, 1, 6));
    drive(nop()); drive(nop()); drive(nop());

    drive(ldi(2, 8));
    repeat (4) drive(add(9, 4, 2));
    drive(nop()); drive(nop()); drive(nop());

    drive(add(31, 1, 1)); drive(add(31, 31, 31));
    drive(add(3, 4, 4)); drive(add(3, 5, 5));
    drive(add(10, 3, 6));
    drive(nop()); drive(nop()); drive(nop());

    x = add(11, 12, 13); x.irq = 1; x.br = 1;
    repeat (4) drive(x);
    x.irq = 0; x.sup = 1; drive(x); drive(x);
    x.sup = 0; drive(x); drive(x);
    x = add(11, 12, 13); x.irq = 1; x.sup = 1;
    repeat (3) drive(x);
    x.irq = 0; drive(x); drive(x);
    x.sup = 0; drive(x);

    drive(ldi(2, 8)); drive(add(9, 2, 4));
    x = add(9, 2, 4); x.rst = 1; drive(x);
    drive(add(9, 2, 4)); drive(add(9, 2, 4));
    drive(nop());

    for (int n = 0; n < 3000; n++) begin
      x = '{default: 0};
      x.v   = ($urandom_range(0, 7) != 0);
      x.ra  = pick_reg();
      x.rb  = pick_reg();
      x.rc  = pick_reg();
      x.ua  = $urandom_range(0, 1);
      x.ub  = $urandom_range(0, 1);
      x.wr  = ($urandom_range(0, 3) != 0);
      x.ld  = ($urandom_range(0, 2) == 0);
      x.br  = ($urandom_range(0, 4) == 0);
      x.sup = ($urandom_range(0, 3) == 0);
      x.irq = ($urandom_range(0, 3) == 0) ? ~irq : irq;
      x.rst = ($urandom_range(0, 99) == 0);
      drive(x);
    end

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    if (exp_q.size() > 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: got %0d left required 0",
               exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
